// File: rtl/mv_run_sequencer.sv
// mv_run_sequencer: run-level sequencer for the 6x6 matrix-vector engine controller.
// Sits between the host register interface and the engine controller. It accepts a run
// command (width, iteration), validates it, takes the vector BRAM port away from the host,
// holds the controller's run enable until the engine reports finish (or abort/timeout), lets
// the pipeline drain, and reports done / err_code / irq back to the host.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit on RUN cycles, 0 disables (must fit the 21-bit counter)
//   DRAIN_CYCLES    cycles running stays low before DONE, 1..15
//   MAX_WIDTH       largest legal width
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       run request handshake, ready only in IDLE
//   cmd_width/cmd_iteration   requested run shape
//   abort                     host abort (level)
//   irq_clr                   clears the sticky irq
//   host_req/host_gnt         host vector-BRAM access in flight / host owns the port
//   running, width, iteration controller run enable and latched run shape
//   finish                    one-cycle completion pulse from the controller
//   busy, done, err_code, irq status back to the host
//   cycle_count               RUN cycle count
//
// Optional feature: define MV_RUN_SEQUENCER_PERF_EN to build the saturating RUN cycle
// counter on cycle_count; otherwise cycle_count is tied to zero.

module mv_run_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned MAX_WIDTH      = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_width,
  input  logic [15:0] cmd_iteration,
  input  logic        abort,
  input  logic        irq_clr,
  input  logic        host_req,
  output logic        host_gnt,
  output logic        running,
  output logic [8:0]  width,
  output logic [15:0] iteration,
  input  logic        finish,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic        irq,
  output logic [31:0] cycle_count
);

  localparam logic [2:0]  ErrOk      = 3'd0;
  localparam logic [2:0]  ErrWidth   = 3'd1;
  localparam logic [2:0]  ErrIter    = 3'd2;
  localparam logic [2:0]  ErrAbort   = 3'd3;
  localparam logic [2:0]  ErrTimeout = 3'd4;

  localparam logic [20:0] WdLimit   = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  DrainLoad = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StArm,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        host_gnt_q, host_gnt_d;
  logic        running_q, running_d;
  logic [8:0]  width_q, width_d;
  logic [15:0] iteration_q, iteration_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  err_q, err_d;
  logic        irq_q, irq_d;
  logic [20:0] wd_q, wd_d;
  logic [3:0]  drain_q, drain_d;

  logic accept;
  logic run_entry;
  logic bad_width;
  logic timeout_hit;

  assign accept    = (state_q == StIdle) && cmd_valid && cmd_ready_q;
  assign run_entry = (state_q == StArm) && (state_d == StRun);

  // Multiple-of-6 test on a 9-bit value folds to a constant compare table.
  assign bad_width = (width_q < 9'd6) || ({23'd0, width_q} > MAX_WIDTH) ||
                     ((width_q % 9'd6) != 9'd0);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_q == WdLimit);

  always_comb begin
    state_d     = state_q;
    host_gnt_d  = host_gnt_q;
    width_d     = width_q;
    iteration_d = iteration_q;
    err_d       = err_q;
    wd_d        = wd_q;
    drain_d     = drain_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          width_d     = cmd_width;
          iteration_d = cmd_iteration;
          err_d       = ErrOk;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (bad_width) begin
          err_d   = ErrWidth;
          state_d = StDone;
        end else if (iteration_q == 16'd0) begin
          err_d   = ErrIter;
          state_d = StDone;
        end else begin
          state_d = StArm;
        end
      end
      StArm: begin
        // Grant is never revoked while a host access is in flight.
        if (abort) begin
          err_d   = ErrAbort;
          drain_d = DrainLoad;
          state_d = StDrain;
        end else if (!host_req) begin
          host_gnt_d = 1'b0;
          wd_d       = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        wd_d = wd_q + 21'd1;
        if (finish) begin
          err_d   = ErrOk;
          drain_d = DrainLoad;
          state_d = StDrain;
        end else if (abort) begin
          err_d   = ErrAbort;
          drain_d = DrainLoad;
          state_d = StDrain;
        end else if (timeout_hit) begin
          err_d   = ErrTimeout;
          drain_d = DrainLoad;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_q == 4'd0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      StDone: begin
        host_gnt_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Run enable rises one cycle after the grant falls and drops as RUN is left.
    running_d   = (state_q == StRun) && (state_d == StRun);
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    done_d      = (state_q == StDone);
    // Set wins over clear both in DONE and in the cycle done is visible.
    if ((state_q == StDone) || done_q) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      host_gnt_q  <= 1'b1;
      running_q   <= 1'b0;
      width_q     <= '0;
      iteration_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ErrOk;
      irq_q       <= 1'b0;
      wd_q        <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      host_gnt_q  <= host_gnt_d;
      running_q   <= running_d;
      width_q     <= width_d;
      iteration_q <= iteration_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      wd_q        <= wd_d;
      drain_q     <= drain_d;
    end
  end

`ifdef MV_RUN_SEQUENCER_PERF_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (accept || run_entry) begin
      cyc_q <= '0;
    end else if ((state_q == StRun) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign host_gnt  = host_gnt_q;
  assign running   = running_q;
  assign width     = width_q;
  assign iteration = iteration_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mv_run_sequencer.sv
// Self-checking bench for mv_run_sequencer. Each command's timeline (accept edge, grant drop,
// run window, done edge, final error) is computed arithmetically from the command and its
// injected events, then every cycle's outputs are compared against that timeline.

module tb_mv_run_sequencer;

  localparam int TO    = 64;
  localparam int DRAIN = 2;
  localparam int MAXW  = 384;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_width;
  logic [15:0] cmd_iteration;
  logic        abort;
  logic        irq_clr;
  logic        host_req;
  logic        host_gnt;
  logic        running;
  logic [8:0]  width;
  logic [15:0] iteration;
  logic        finish;
  logic        busy;
  logic        done;
  logic [2:0]  err_code;
  logic        irq;
  logic [31:0] cycle_count;

  logic [8:0]  obs;
  assign obs = {cmd_ready, host_gnt, running, busy, done, irq, err_code};

  int          checks = 0;
  int          errors = 0;
  logic        irq_m;
  logic [2:0]  err_m;

  always #5 clk = ~clk;

  mv_run_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .DRAIN_CYCLES  (DRAIN),
    .MAX_WIDTH     (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_width    (cmd_width),
    .cmd_iteration(cmd_iteration),
    .abort        (abort),
    .irq_clr      (irq_clr),
    .host_req     (host_req),
    .host_gnt     (host_gnt),
    .running      (running),
    .width        (width),
    .iteration    (iteration),
    .finish       (finish),
    .busy         (busy),
    .done         (done),
    .err_code     (err_code),
    .irq          (irq),
    .cycle_count  (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    cmd_valid     = 1'b0;
    cmd_width     = '0;
    cmd_iteration = '0;
    abort         = 1'b0;
    irq_clr       = 1'b0;
    host_req      = 1'b0;
    finish        = 1'b0;
  endtask

  // Idle cycles; vector is {cmd_ready, host_gnt, running, busy, done, irq, err_code}.
  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      quiet_inputs();
      irq_clr = clr;
      @(posedge clk);
      #1;
      if (clr) irq_m = 1'b0;
      check("idle", 32'(obs), 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, irq_m, err_m}));
    end
  endtask

  // mode: 0 no abort, 1 abort in ARM, 2 abort at RUN offset ad. fd: finish RUN offset, -1 none.
  // r: cycles host_req stays high in ARM. clr_done: irq_clr during the done cycle.
  task automatic run_txn(input logic [8:0] w, input logic [15:0] it, input int r, input int mode,
                         input int fd, input int ad, input bit clr_done);
    int         rk, g, e, d, eset, cnt;
    logic [2:0] ferr;
    bit         bad_w, bad_i, runpath, gdrop, rdy_e, run_e, gnt_e;
    bad_w   = (w < 6) || (int'(w) > MAXW) || ((w % 6) != 0);
    bad_i   = (it == 16'd0);
    g       = 2 + r;        // edge at which the grant drops
    rk      = 3 + r;        // first RUN edge after which running is visible
    e       = 0;
    cnt     = 0;
    runpath = 1'b0;
    gdrop   = 1'b0;
    if (bad_w) begin
      ferr = 3'd1; eset = 1; d = 2;
    end else if (bad_i) begin
      ferr = 3'd2; eset = 1; d = 2;
    end else if (mode == 1) begin
      ferr = 3'd3; eset = 2; d = 2 + DRAIN + 1;
    end else begin
      runpath = 1'b1;
      gdrop   = 1'b1;
      e       = rk + TO - 1;
      ferr    = 3'd4;
      if (mode == 2 && rk + ad <= e) begin e = rk + ad; ferr = 3'd3; end
      if (fd >= 0 && rk + fd <= e) begin e = rk + fd; ferr = 3'd0; end
      eset = e;
      d    = e + DRAIN + 1;
      cnt  = e - rk + 1;
    end

    for (int k = 0; k <= d + 1; k++) begin
      cmd_valid     = (k == 0) || (k <= d && $urandom_range(0, 3) == 0);
      cmd_width     = (k == 0) ? w : 9'($urandom);
      cmd_iteration = (k == 0) ? it : 16'($urandom);
      host_req      = (r > 0) && (k < 2 + r);
      finish        = runpath && ((fd >= 0 && k == rk + fd) || k == e + 1);
      abort         = (!bad_w && !bad_i && mode == 1 && k == 2) ||
                      (runpath && mode == 2 && k == rk + ad) || (runpath && k == e + 1);
      irq_clr       = (clr_done && k == d + 1) || (k > 0 && k < d && $urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
      if (k == d || k == d + 1) irq_m = 1'b1;
      else if (irq_clr) irq_m = 1'b0;
      if (k == 0) err_m = 3'd0;
      if (k == eset) err_m = ferr;
      rdy_e = (k >= d);
      run_e = runpath && k >= rk && k < e;
      gnt_e = !(gdrop && k >= g && k < d);
      check("cycle", 32'(obs), 32'({rdy_e, gnt_e, run_e, !rdy_e, k == d, irq_m, err_m}));
      check("excl", 32'(host_gnt & running), 32'd0);
      if (k == d) begin
        check("width", 32'(width), 32'(w));
        check("iteration", 32'(iteration), 32'(it));
`ifdef MV_RUN_SEQUENCER_PERF_EN
        check("cycle_count", cycle_count, 32'(cnt));
`else
        check("cycle_count", cycle_count, 32'd0);
`endif
      end
    end
    quiet_inputs();
  endtask

  task automatic reset_mid();
    quiet_inputs();
    cmd_valid     = 1'b1;
    cmd_width     = 9'd12;
    cmd_iteration = 16'd1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    check("pre_rst_running", 32'(running), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    irq_m = 1'b0;
    err_m = 3'd0;
    check("rst_vec", 32'(obs), 32'(9'b110000000));
    check("rst_width", 32'(width), 32'd0);
    check("rst_iter", 32'(iteration), 32'd0);
    check("rst_cyc", cycle_count, 32'd0);
    idle(4, 1'b0);
  endtask

  initial begin
    quiet_inputs();
    rst   = 1'b1;
    irq_m = 1'b0;
    err_m = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(obs), 32'(9'b110000000));
    check("reset_width", 32'(width), 32'd0);
    check("reset_iter", 32'(iteration), 32'd0);
    check("reset_cyc", cycle_count, 32'd0);
    rst = 1'b0;
    idle(2, 1'b0);

    run_txn(9'd12, 16'd3, 0, 0, 50, 0, 1'b0);   // normal run
    idle(2, 1'b1);
    run_txn(9'd13, 16'd5, 0, 0, -1, 0, 1'b0);   // width not a multiple of 6
    run_txn(9'd390, 16'd5, 0, 0, -1, 0, 1'b0);  // width above MAX_WIDTH
    run_txn(9'd0, 16'd0, 0, 0, -1, 0, 1'b0);    // both bad: width reported
    run_txn(9'd6, 16'd0, 0, 0, -1, 0, 1'b0);    // iteration zero
    run_txn(9'd384, 16'd1, 0, 0, 3, 0, 1'b0);   // largest legal width
    idle(1, 1'b1);
    run_txn(9'd12, 16'd7, 5, 0, 10, 0, 1'b0);   // host holds the port for 5 cycles
    run_txn(9'd24, 16'd2, 0, 2, -1, 7, 1'b0);   // abort in RUN
    run_txn(9'd24, 16'd2, 0, 2, 9, 9, 1'b0);    // abort and finish together
    run_txn(9'd30, 16'd1, 2, 1, -1, 0, 1'b0);   // abort in ARM
    run_txn(9'd36, 16'd4, 0, 0, -1, 0, 1'b0);   // watchdog timeout
    idle(1, 1'b1);
    run_txn(9'd42, 16'd4, 1, 0, -1, 0, 1'b1);   // timeout, irq_clr with done
    reset_mid();
    run_txn(9'd12, 16'd3, 0, 0, 20, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [8:0]  w;
      logic [15:0] it;
      if ($urandom_range(0, 3) != 0) w = 9'(6 * $urandom_range(1, 64));
      else w = 9'($urandom_range(0, 511));
      it = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      run_txn(w, it, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 80)),
              int'($urandom_range(0, 80)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
